mipi_csi2_pkt_gen: RTL and testbench
====================================

MIPI_CSI2_PKT_GEN -- requirements
Module: mipi_csi2_pkt_gen

Interface
REQ-001 SHALL have parameter SHORT_DT_MAX, default 6'h0F: data types <= this value form short packets; all others form long packets.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk_hs in 1, HS byte clock, sole clock; resetb in 1, async active-low reset.
REQ-003 pkt_start  in  1  request pulse; header fields sampled when pkt_start && pkt_ready.
REQ-004 pkt_di  in  8  data identifier {VC[1:0], DT[5:0]}.
REQ-005 pkt_wc  in  16  long: payload byte count; short: 16-bit short-packet data field.
REQ-006 pkt_ready  out  1  block idle and able to accept a request.
REQ-007 pay_data  in  8  payload byte.
REQ-008 pay_valid  in  1  pay_data valid.
REQ-009 pay_ready  out  1  payload byte consumed this cycle.
REQ-010 hs_req  out  1  HS burst request to the PHY serializer.
REQ-011 phy_re  in  1  PHY ready; while high the PHY takes one data_out byte per cycle.
REQ-012 data_out  out  8  byte to the PHY.
REQ-013 underrun  out  1  sticky: payload byte was not available when needed.
REQ-014 abort  out  1  sticky: phy_re dropped mid-packet.
REQ-015 err_clr  in  1  clears underrun and abort.

Function
REQ-016 States SHALL be IDLE, SOT, DI, WC0, WC1, ECC, PAY, CRC0, CRC1.
REQ-017 IDLE: pkt_ready=1 and hs_req=0; on pkt_start, latch pkt_di/pkt_wc, go to SOT, set pkt_ready=0, and assert hs_req on the next cycle.
REQ-018 SOT: hold until phy_re=1, then go to DI.
REQ-019 From DI on, advance one state per cycle: data_out = di, wc[7:0], wc[15:8], ecc, in order.
REQ-020 ECC: CSI-2 6-bit Hamming code over the 24 header bits {wc[15:0], di}, with ecc[7:6]=0.
REQ-021 Short packet: after ECC go to IDLE; hs_req deasserts on the cycle after the ECC byte.
REQ-022 Long packet: after ECC go to PAY; load a 16-bit down-counter with wc.
REQ-023 PAY: each cycle, output one byte, assert pay_ready when pay_valid=1, and decrement the counter; leave PAY when the counter reaches 0.
REQ-024 PAY with pay_valid=0: output 8'h00 (included in the CRC), set underrun, do not assert pay_ready, and still decrement the counter (HS bursts cannot stall).
REQ-025 wc=0 long packet: skip PAY and go directly from ECC to CRC0.
REQ-026 CRC0/CRC1: output crc[7:0], then crc[15:8]; return to IDLE, with hs_req low on the cycle after CRC1.
REQ-027 phy_re=0 in any state from DI through CRC1: go to IDLE, drop hs_req, set abort, and drain no payload.
REQ-028 pkt_start outside IDLE SHALL be ignored.
REQ-029 err_clr and a simultaneous error event: the set wins.
REQ-030 data_out SHALL be registered and hold its last value in IDLE/SOT.

Reset
REQ-031 On resetb low, immediately and asynchronously: state=IDLE, hs_req=0, data_out=8'h00, pkt_ready=1, pay_ready=0, underrun=0, abort=0, CRC register=16'hFFFF.
REQ-032 Reset mid-packet SHALL truncate the burst, with no CRC sent; the first pkt_start after release SHALL be accepted normally.

Configuration
REQ-033 Macro MIPI_CSI2_PKT_GEN_CRC_EN defined: CRC-16 is computed per byte, LSB-first.
- Polynomial x^16+x^12+x^5+1 (reflected 16'h8408), seed 16'hFFFF reloaded at ECC, no final XOR.
REQ-034 Macro undefined: no CRC logic; CRC0/CRC1 bytes are 8'h00 (checksum not computed); all other timing unchanged.

Verification
REQ-035 Short packet, di=8'h00, wc=16'h0001, phy_re high from SOT -> data_out 00,01,00,ECC; hs_req low the next cycle; pkt_ready back to 1.
REQ-036 Header ECC, di=8'h37, wc=16'h01F0 -> bytes 37,F0,01,3F.
REQ-037 CRC_EN defined, long packet, di=8'h2A, wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> CRC bytes F0,00; underrun=0.
REQ-038 Long packet, wc=4, pay_valid low for byte 2 -> byte 2 = 00, underrun=1, CRC covers the 00, total 10 bytes; err_clr clears underrun.
REQ-039 phy_re drops during PAY -> next cycle state IDLE, hs_req=0, abort=1; a following short packet is sent correctly.
REQ-040 Long packet with wc=0 -> DI, 00, 00, ECC, FF, FF with CRC_EN; 00, 00 without.

Source files
------------

// File: rtl/mipi_csi2_pkt_gen.sv
// MIPI CSI-2 packet generator: header + ECC, payload, CRC-16 trailer.
// Optional CRC: define MIPI_CSI2_PKT_GEN_CRC_EN (else CRC bytes are 00).
module mipi_csi2_pkt_gen #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        clk_hs,
  input  logic        resetb,
  input  logic        pkt_start,
  input  logic [7:0]  pkt_di,
  input  logic [15:0] pkt_wc,
  output logic        pkt_ready,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic        hs_req,
  input  logic        phy_re,
  output logic [7:0]  data_out,
  output logic        underrun,
  output logic        abort,
  input  logic        err_clr
);

  typedef enum logic [3:0] {
    IDLE, SOT, DI, WC0, WC1, ECC, PAY, CRC0, CRC1
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic        r_hs_req;
  logic [7:0]  r_data_out;
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic [15:0] r_cnt;
  logic        r_underrun;
  logic        r_abort;
  logic        w_emit;
  logic        w_busy;
  logic        w_long;
  logic        w_pkt_ready;
  logic        w_und_set;
  logic        w_abt_set;
  logic [7:0]  w_byte;
  logic [5:0]  w_ecc;
  logic [15:0] w_crc;

  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10]
         ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10]
         ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11]
         ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13]
         ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = (^d[9:4]) ^ (^d[20:16]) ^ d[22] ^ d[23];
    p[5] = (^d[19:10]) ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  assign w_ecc       = hdr_ecc({r_wc, r_di});
  assign w_long      = (r_di[5:0] > SHORT_DT_MAX);
  assign w_busy      = (r_state != IDLE) && (r_state != SOT);
  assign w_pkt_ready = (r_state == IDLE) && !r_hs_req;
  assign w_und_set   = (r_state == PAY) && phy_re && !pay_valid;
  assign w_abt_set   = w_busy && !phy_re;

  assign pkt_ready = w_pkt_ready;
  assign pay_ready = (r_state == PAY) && phy_re && pay_valid;
  assign hs_req    = r_hs_req;
  assign data_out  = r_data_out;
  assign underrun  = r_underrun;
  assign abort     = r_abort;

`ifdef MIPI_CSI2_PKT_GEN_CRC_EN
  logic [15:0] r_crc;

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // reseed at ECC, fold in every payload byte actually sent
  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb)                         r_crc <= 16'hFFFF;
    else if (r_state == ECC)             r_crc <= 16'hFFFF;
    else if (r_state == PAY && phy_re)   r_crc <= crc_byte(r_crc, w_byte);
  end

  assign w_crc = r_crc;
`else
  assign w_crc = 16'h0000;
`endif

  // next state and the byte to launch this cycle
  always_comb begin
    w_nxt  = r_state;
    w_emit = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      IDLE: if (pkt_start && w_pkt_ready) w_nxt = SOT;
      SOT:  if (phy_re) w_nxt = DI;
      DI: begin
        w_byte = r_di;
        w_nxt  = WC0;
      end
      WC0: begin
        w_byte = r_wc[7:0];
        w_nxt  = WC1;
      end
      WC1: begin
        w_byte = r_wc[15:8];
        w_nxt  = ECC;
      end
      ECC: begin
        w_byte = {2'b00, w_ecc};
        if (!w_long)           w_nxt = IDLE;
        else if (r_wc == '0)   w_nxt = CRC0;
        else                   w_nxt = PAY;
      end
      PAY: begin
        w_byte = pay_valid ? pay_data : 8'h00;
        w_nxt  = (r_cnt == 16'd1) ? CRC0 : PAY;
      end
      CRC0: begin
        w_byte = w_crc[7:0];
        w_nxt  = CRC1;
      end
      CRC1: begin
        w_byte = w_crc[15:8];
        w_nxt  = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_busy) begin
      if (phy_re) w_emit = 1'b1;
      else        w_nxt  = IDLE;
    end
  end

  // state, burst request and output byte
  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb) begin
      r_state    <= IDLE;
      r_hs_req   <= 1'b0;
      r_data_out <= 8'h00;
    end else begin
      r_state  <= w_nxt;
      r_hs_req <= (w_nxt != IDLE) || w_emit;
      if (w_emit) r_data_out <= w_byte;
    end
  end

  // header latch and payload down-counter
  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb) begin
      r_di  <= 8'h00;
      r_wc  <= 16'h0000;
      r_cnt <= 16'h0000;
    end else begin
      if (r_state == IDLE && pkt_start && w_pkt_ready) begin
        r_di <= pkt_di;
        r_wc <= pkt_wc;
      end
      if (r_state == ECC)
        r_cnt <= r_wc;
      else if (r_state == PAY && phy_re)
        r_cnt <= r_cnt - 16'd1;
    end
  end

  // sticky error flags, a new event beats a clear
  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb) begin
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (w_und_set)    r_underrun <= 1'b1;
      else if (err_clr) r_underrun <= 1'b0;
      if (w_abt_set)    r_abort <= 1'b1;
      else if (err_clr) r_abort <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mipi_csi2_pkt_gen.sv
// Bench for mipi_csi2_pkt_gen: random packets, scoreboard on data_out.
// Expected bytes come from an ECC column table and a bitwise CRC model.
module tb_mipi_csi2_pkt_gen;

  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;
`ifdef MIPI_CSI2_PKT_GEN_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk_hs = 1'b0;
  logic        resetb;
  logic        pkt_start;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic        pkt_ready;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic        hs_req;
  logic        phy_re;
  logic [7:0]  data_out;
  logic        underrun;
  logic        abort;
  logic        err_clr;

  mipi_csi2_pkt_gen #(.SHORT_DT_MAX(SHORT_DT_MAX)) dut (
    .clk_hs(clk_hs), .resetb(resetb),
    .pkt_start(pkt_start), .pkt_di(pkt_di), .pkt_wc(pkt_wc),
    .pkt_ready(pkt_ready),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .hs_req(hs_req), .phy_re(phy_re), .data_out(data_out),
    .underrun(underrun), .abort(abort), .err_clr(err_clr)
  );

  always #5 clk_hs = ~clk_hs;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_src[$];
  logic [7:0] last_b = 8'h00;
  bit         m_und = 1'b0;
  bit         m_abt = 1'b0;
  bit         mon_en = 1'b1;
  bit         m_prev = 1'b0;
  bit         m_in = 1'b0;
  logic [7:0] m_e;

  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [7:0] m_ecc(input logic [7:0] di,
                                       input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] m_crc(input logic [15:0] c,
                                        input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  // PHY side: byte launched when hs_req&&phy_re (after SOT) shows next cycle
  always @(negedge clk_hs) begin
    if (!resetb || !mon_en) begin
      m_prev = 1'b0;
      m_in   = 1'b0;
    end else begin
      if (hs_req && m_prev) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_out got=%h required=none", data_out);
        end else begin
          m_e = exp_q.pop_front();
          if (data_out !== m_e) begin
            n_fail++;
            $display("FAIL data_out got=%h required=%h", data_out, m_e);
          end
        end
      end
      m_prev = hs_req && phy_re && m_in;
      if (!hs_req)     m_in = 1'b0;
      else if (phy_re) m_in = 1'b1;
    end
  end

  task automatic wait_ready();
    int to;
    to = 0;
    @(negedge clk_hs);
    while (!pkt_ready && to < 50) begin
      @(negedge clk_hs);
      to++;
    end
    chk("pkt_ready_idle", 16'(pkt_ready), 16'd1);
  endtask

  task automatic send(input logic [7:0] di, input logic [15:0] wc,
                      input int sot_wait, input int abort_at,
                      input int gap_pct, input int inv_pay,
                      input int clr_at);
    logic [7:0]  hdr [4];
    logic [7:0]  b, pd;
    logic [15:0] crc;
    bit          lng, ispay, pv, su, sa, abd;
    int          nb, k;
    lng = (di[5:0] > SHORT_DT_MAX);
    nb  = lng ? 6 + int'(wc) : 4;
    hdr[0] = di;
    hdr[1] = wc[7:0];
    hdr[2] = wc[15:8];
    hdr[3] = m_ecc(di, wc);
    crc = 16'hFFFF;
    abd = 1'b0;
    wait_ready();
    @(posedge clk_hs); #1;
    pkt_start = 1'b1;
    pkt_di    = di;
    pkt_wc    = wc;
    phy_re    = 1'b0;
    err_clr   = 1'b0;
    @(posedge clk_hs); #1;
    for (int s = 0; s <= sot_wait; s++) begin
      pkt_start = 1'($urandom_range(0, 1));
      pkt_di    = 8'($urandom);
      pkt_wc    = 16'($urandom);
      phy_re    = (s == sot_wait);
      @(negedge clk_hs);
      if (s == 0) begin
        chk("hs_req_sot", 16'(hs_req), 16'd1);
        chk("pkt_ready_busy", 16'(pkt_ready), 16'd0);
        chk("data_out_hold", 16'(data_out), 16'(last_b));
      end
      @(posedge clk_hs); #1;
    end
    for (int j = 0; j < nb; j++) begin
      ispay = lng && j >= 4 && j < nb - 2;
      k  = j - 4;
      if (pay_src.size() != 0) pv = 1'b1;
      else pv = (k != inv_pay) && ($urandom_range(0, 99) >= gap_pct);
      pd = (pay_src.size() != 0 && ispay) ? pay_src[k] : 8'($urandom);
      pay_valid = pv;
      pay_data  = pd;
      phy_re    = (j != abort_at);
      err_clr   = (j == clr_at);
      pkt_start = 1'($urandom_range(0, 1));
      su = 1'b0;
      sa = 1'b0;
      if (j == abort_at) begin
        sa  = 1'b1;
        abd = 1'b1;
      end else begin
        if (j < 4) b = hdr[j];
        else if (ispay) begin
          b   = pv ? pd : 8'h00;
          su  = !pv;
          crc = m_crc(crc, b);
        end
        else if (j == nb - 2) b = CRC_ON ? crc[7:0] : 8'h00;
        else                  b = CRC_ON ? crc[15:8] : 8'h00;
        exp_q.push_back(b);
        last_b = b;
      end
      m_und = su | (m_und & !err_clr);
      m_abt = sa | (m_abt & !err_clr);
      @(negedge clk_hs);
      chk("pay_ready", 16'(pay_ready),
          16'(ispay && pv && (j != abort_at)));
      @(posedge clk_hs); #1;
      if (j == abort_at) break;
    end
    pkt_start = 1'b0;
    pay_valid = 1'b0;
    err_clr   = 1'b0;
    phy_re    = 1'($urandom_range(0, 1));
    @(negedge clk_hs);
    chk("hs_req_after", 16'(hs_req), 16'(!abd));
    chk("pkt_ready_after", 16'(pkt_ready), 16'(abd));
    chk("underrun", 16'(underrun), 16'(m_und));
    chk("abort", 16'(abort), 16'(m_abt));
  endtask

  task automatic clear_errs();
    @(posedge clk_hs); #1;
    err_clr = 1'b1;
    @(posedge clk_hs); #1;
    err_clr = 1'b0;
    m_und = 1'b0;
    m_abt = 1'b0;
    @(negedge clk_hs);
    chk("underrun_clr", 16'(underrun), 16'd0);
    chk("abort_clr", 16'(abort), 16'd0);
  endtask

  task automatic reset_mid();
    wait_ready();
    mon_en = 1'b0;
    @(posedge clk_hs); #1;
    pkt_start = 1'b1;
    pkt_di    = 8'h2A;
    pkt_wc    = 16'd20;
    phy_re    = 1'b1;
    pay_valid = 1'b0;
    @(posedge clk_hs); #1;
    pkt_start = 1'b0;
    repeat (6) @(posedge clk_hs);
    #1;
    pay_valid = 1'b1;
    #1;
    chk("pay_ready_pre_rst", 16'(pay_ready), 16'd1);
    chk("underrun_pre_rst", 16'(underrun), 16'd1);
    resetb = 1'b0;
    #1;
    chk("rst_hs_req", 16'(hs_req), 16'd0);
    chk("rst_data_out", 16'(data_out), 16'd0);
    chk("rst_pkt_ready", 16'(pkt_ready), 16'd1);
    chk("rst_pay_ready", 16'(pay_ready), 16'd0);
    chk("rst_underrun", 16'(underrun), 16'd0);
    chk("rst_abort", 16'(abort), 16'd0);
    @(posedge clk_hs); #1;
    resetb    = 1'b1;
    pay_valid = 1'b0;
    phy_re    = 1'b0;
    exp_q.delete();
    last_b = 8'h00;
    m_und  = 1'b0;
    m_abt  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  di;
    logic [15:0] wc;
    int          nb, ab, cl;
    pkt_start = 1'b0;
    pkt_di    = 8'h00;
    pkt_wc    = 16'h0000;
    pay_data  = 8'h00;
    pay_valid = 1'b0;
    phy_re    = 1'b0;
    err_clr   = 1'b0;
    resetb    = 1'b0;
    #12;
    chk("init_hs_req", 16'(hs_req), 16'd0);
    chk("init_pkt_ready", 16'(pkt_ready), 16'd1);
    chk("init_data_out", 16'(data_out), 16'd0);
    chk("init_pay_ready", 16'(pay_ready), 16'd0);
    chk("init_underrun", 16'(underrun), 16'd0);
    chk("init_abort", 16'(abort), 16'd0);
    @(posedge clk_hs); #1;
    resetb = 1'b1;

    send(8'h00, 16'h0001, 2, -1, 0, -1, -1);
    send(8'h37, 16'h01F0, 0, -1, 0, -1, -1);
    pay_src = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    send(8'h2A, 16'd24, 1, -1, 0, -1, -1);
    pay_src.delete();
    send(8'h2A, 16'd4, 1, -1, 0, 2, -1);
    clear_errs();
    send(8'h2A, 16'd8, 0, 6, 0, -1, -1);
    send(8'h01, 16'hA55A, 0, -1, 0, -1, -1);
    send(8'h2A, 16'd0, 1, -1, 0, -1, -1);
    send(8'h2B, 16'd4, 0, -1, 0, 1, 5);
    clear_errs();
    reset_mid();
    send(8'h12, 16'h1234, 0, -1, 0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      di = 8'($urandom);
      if (di[5:0] > SHORT_DT_MAX) wc = 16'($urandom_range(0, 12));
      else                        wc = 16'($urandom);
      nb = (di[5:0] > SHORT_DT_MAX) ? 6 + int'(wc) : 4;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      cl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      send(di, wc, int'($urandom_range(0, 3)), ab, 20, -1, cl);
      if ($urandom_range(0, 6) == 0) clear_errs();
    end

    repeat (4) @(negedge clk_hs);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
